// File: rtl/irq_ctrl_pkg.sv
// Shared register map and VECTOR field layout for the irq_ctrl interrupt controller.
package irq_ctrl_pkg;
    localparam logic [2:0] ADDR_PENDING = 3'd0;
    localparam logic [2:0] ADDR_MASK    = 3'd1;
    localparam logic [2:0] ADDR_EDGE    = 3'd2;
    localparam logic [2:0] ADDR_RAW     = 3'd3;
    localparam logic [2:0] ADDR_VECTOR  = 3'd4;
    localparam logic [2:0] ADDR_HOLDOFF = 3'd5;
    localparam logic [2:0] ADDR_SWI     = 3'd6;

    localparam int VECTOR_VALID_BIT = 15;
    localparam int VECTOR_IDX_W     = 4;
    localparam int DATA_W           = 16;
endpackage

// File: rtl/irq_ctrl_if.sv
// Avalon-MM 16-bit slave bus between the CPU side and irq_ctrl.
interface irq_ctrl_if;
    import irq_ctrl_pkg::*;
    logic [2:0]        address;
    logic              chipselect;
    logic              write_n;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/irq_prio_enc.sv
// Lowest-set-bit encoder: index 0 has the highest priority.
module irq_prio_enc
    import irq_ctrl_pkg::*;
#(
    parameter int N_IRQ = 4
) (
    input  logic [N_IRQ-1:0]        i_req,
    output logic                    o_valid,
    output logic [VECTOR_IDX_W-1:0] o_idx
);
    always_comb begin
        o_valid = |i_req;
        o_idx   = '0;
        // Scan downward so the lowest set index is the last assignment.
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (i_req[i]) o_idx = VECTOR_IDX_W'(i);
        end
    end
endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: edge/level capture, masking, lowest-index priority, registered irq.
// Optional irq holdoff after a VECTOR ack is enabled by defining IRQ_CTRL_HOLDOFF_EN.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int          N_IRQ        = 4,
    parameter logic [14:0] EDGE_DEFAULT = '0,
    parameter int          HOLDOFF_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    irq_ctrl_if.slave        bus,
    input  logic [N_IRQ-1:0] irq_in,
    output logic             irq
);
    if (N_IRQ < 1 || N_IRQ > 15) $error("irq_ctrl: N_IRQ out of range");
    if (HOLDOFF_W < 1 || HOLDOFF_W > 16) $error("irq_ctrl: HOLDOFF_W out of range");

    logic [N_IRQ-1:0] r_pending, r_mask, r_edge, r_irq_q;
    logic [N_IRQ-1:0] w_set, w_clr, w_swi, w_wdata;
    logic             w_wr, w_vld, w_ack, w_holdoff_active;
    logic [VECTOR_IDX_W-1:0] w_idx;
    logic [DATA_W-1:0]       w_rdata;

    assign w_wr    = bus.chipselect & ~bus.write_n;
    assign w_wdata = bus.writedata[N_IRQ-1:0];
    assign w_set   = irq_in & (~r_edge | ~r_irq_q);
    assign w_ack   = w_wr && (bus.address == ADDR_VECTOR) && w_vld;
    assign w_swi   = (w_wr && bus.address == ADDR_SWI) ? w_wdata : '0;

    irq_prio_enc #(.N_IRQ(N_IRQ)) u_prio (
        .i_req   (r_pending & r_mask),
        .o_valid (w_vld),
        .o_idx   (w_idx)
    );

    always_comb begin
        w_clr = '0;
        if (w_wr && bus.address == ADDR_PENDING) w_clr = w_wdata;
        if (w_ack) w_clr = N_IRQ'(1) << w_idx;
    end

`ifdef IRQ_CTRL_HOLDOFF_EN
    logic [HOLDOFF_W-1:0] r_holdoff_reg, r_holdoff_cnt;
    assign w_holdoff_active = |r_holdoff_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_holdoff_reg <= '0;
            r_holdoff_cnt <= '0;
        end else begin
            if (w_wr && bus.address == ADDR_HOLDOFF) r_holdoff_reg <= bus.writedata[HOLDOFF_W-1:0];
            if (w_ack) r_holdoff_cnt <= r_holdoff_reg;
            else if (w_holdoff_active) r_holdoff_cnt <= r_holdoff_cnt - 1'b1;
        end
    end
`else
    assign w_holdoff_active = 1'b0;
`endif

    always_comb begin
        w_rdata = '0;
        case (bus.address)
            ADDR_PENDING: w_rdata[N_IRQ-1:0] = r_pending;
            ADDR_MASK:    w_rdata[N_IRQ-1:0] = r_mask;
            ADDR_EDGE:    w_rdata[N_IRQ-1:0] = r_edge;
            ADDR_RAW:     w_rdata[N_IRQ-1:0] = r_irq_q;
            ADDR_VECTOR: begin
                w_rdata[VECTOR_VALID_BIT]     = w_vld;
                w_rdata[VECTOR_IDX_W-1:0]     = w_idx;
            end
`ifdef IRQ_CTRL_HOLDOFF_EN
            ADDR_HOLDOFF: w_rdata[HOLDOFF_W-1:0] = r_holdoff_reg;
`endif
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending    <= '0;
            r_mask       <= '0;
            r_edge       <= EDGE_DEFAULT[N_IRQ-1:0];
            r_irq_q      <= '0;
            bus.readdata <= '0;
            irq          <= 1'b0;
        end else begin
            r_irq_q      <= irq_in;
            // Set and software trigger win over a simultaneous clear.
            r_pending    <= (r_pending & ~w_clr) | w_set | w_swi;
            if (w_wr && bus.address == ADDR_MASK) r_mask <= w_wdata;
            if (w_wr && bus.address == ADDR_EDGE) r_edge <= w_wdata;
            bus.readdata <= w_rdata;
            irq          <= (|(r_pending & r_mask)) & ~w_holdoff_active;
        end
    end
endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl (N_IRQ=4, level default); holdoff checks follow IRQ_CTRL_HOLDOFF_EN.
module tb_irq_ctrl;
    import irq_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] irq_in;
    logic       irq;
    int         checks = 0;
    int         failures = 0;
    logic [15:0] rdv;

    irq_ctrl_if bus ();

    irq_ctrl #(.N_IRQ(4), .EDGE_DEFAULT(15'h0), .HOLDOFF_W(16)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .irq_in (irq_in),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.writedata  = d;
        tick(1);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [15:0] d);
        bus.address = a;
        tick(1);
        d = bus.readdata;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset          = 1'b1;
        irq_in         = '0;
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        tick(2);
        check("rst_irq", {15'd0, irq}, 16'h0);
        check("rst_rdata", bus.readdata, 16'h0);
        reset = 1'b0;
        rd(ADDR_PENDING, rdv); check("rst_pending", rdv, 16'h0);
        rd(ADDR_MASK, rdv);    check("rst_mask", rdv, 16'h0);
        rd(ADDR_EDGE, rdv);    check("rst_edge", rdv, 16'h0);

        // Level source 0: pending at +1, irq at +2
        wr(ADDR_MASK, 16'h0001);
        bus.address = ADDR_VECTOR;
        irq_in = 4'b0001;
        tick(1);
        check("lat_irq_t1", {15'd0, irq}, 16'h0);
        check("lat_vec_t1", bus.readdata, 16'h0);
        tick(1);
        check("lat_irq_t2", {15'd0, irq}, 16'h1);
        check("lat_vec_t2", bus.readdata, 16'h8000);

        // W1C while level still high: set wins
        wr(ADDR_PENDING, 16'h0001);
        check("w1c_lvl_irq0", {15'd0, irq}, 16'h1);
        tick(1);
        check("w1c_lvl_irq1", {15'd0, irq}, 16'h1);
        rd(ADDR_PENDING, rdv); check("w1c_lvl_pend", rdv, 16'h0001);
        rd(ADDR_RAW, rdv);     check("raw", rdv, 16'h0001);
        irq_in = 4'b0000;
        tick(1);
        wr(ADDR_PENDING, 16'h0001);
        tick(1);
        check("w1c_irq_low", {15'd0, irq}, 16'h0);

        // Priority and VECTOR ack
        wr(ADDR_EDGE, 16'h0002);
        wr(ADDR_MASK, 16'h0003);
        irq_in = 4'b0011;
        tick(1);
        irq_in = 4'b0001;
        tick(2);
        rd(ADDR_VECTOR, rdv); check("vec_a", rdv, 16'h8000);
        wr(ADDR_VECTOR, 16'h0000);
        rd(ADDR_VECTOR, rdv); check("vec_b", rdv, 16'h8000);
        irq_in = 4'b0000;
        tick(1);
        wr(ADDR_VECTOR, 16'h0000);
        rd(ADDR_VECTOR, rdv); check("vec_c", rdv, 16'h8001);
        wr(ADDR_VECTOR, 16'h0000);
        rd(ADDR_VECTOR, rdv); check("vec_d", rdv, 16'h0000);
        check("vec_irq_low", {15'd0, irq}, 16'h0);

        // Edge on bit 2 coincident with its W1C
        wr(ADDR_EDGE, 16'h0006);
        rd(ADDR_EDGE, rdv); check("edge_rd", rdv, 16'h0006);
        irq_in = 4'b0100;
        tick(1);
        irq_in = 4'b0000;
        tick(1);
        rd(ADDR_PENDING, rdv); check("edge_pend", rdv, 16'h0004);
        irq_in = 4'b0100;
        wr(ADDR_PENDING, 16'h0004);
        irq_in = 4'b0000;
        rd(ADDR_PENDING, rdv); check("edge_vs_clr", rdv, 16'h0004);
        wr(ADDR_PENDING, 16'h0004);
        rd(ADDR_PENDING, rdv); check("edge_clr", rdv, 16'h0000);

        // Upper write bits ignored, reserved address reads 0
        wr(ADDR_MASK, 16'hFFFF);
        rd(ADDR_MASK, rdv); check("mask_width", rdv, 16'h000F);
        rd(3'd7, rdv);      check("reserved", rdv, 16'h0000);

        // Software trigger, then reset mid-interrupt
        wr(ADDR_MASK, 16'h0004);
        wr(ADDR_SWI, 16'h0004);
        tick(1);
        check("swi_irq", {15'd0, irq}, 16'h1);
        rd(ADDR_SWI, rdv); check("swi_rd", rdv, 16'h0000);
        rd(ADDR_PENDING, rdv); check("swi_pend", rdv, 16'h0004);
        reset = 1'b1;
        tick(1);
        check("mid_rst_irq", {15'd0, irq}, 16'h0);
        check("mid_rst_rdata", bus.readdata, 16'h0);
        reset = 1'b0;
        rd(ADDR_PENDING, rdv); check("mid_rst_pend", rdv, 16'h0);
        rd(ADDR_MASK, rdv);    check("mid_rst_mask", rdv, 16'h0);
        rd(ADDR_EDGE, rdv);    check("mid_rst_edge", rdv, 16'h0);
        check("mid_rst_irq2", {15'd0, irq}, 16'h0);

        // Holdoff after VECTOR ack, level source held high
        wr(ADDR_MASK, 16'h0001);
        irq_in = 4'b0001;
        tick(2);
        check("ho_irq_pre", {15'd0, irq}, 16'h1);
        wr(ADDR_HOLDOFF, 16'h0005);
        rd(ADDR_HOLDOFF, rdv);
`ifdef IRQ_CTRL_HOLDOFF_EN
        check("ho_rd", rdv, 16'h0005);
`else
        check("ho_rd", rdv, 16'h0000);
`endif
        wr(ADDR_VECTOR, 16'h0000);
        check("ho_irq_ack", {15'd0, irq}, 16'h1);
        for (int k = 0; k < 5; k++) begin
            tick(1);
`ifdef IRQ_CTRL_HOLDOFF_EN
            check($sformatf("ho_irq_sup%0d", k), {15'd0, irq}, 16'h0);
`else
            check($sformatf("ho_irq_sup%0d", k), {15'd0, irq}, 16'h1);
`endif
        end
        tick(1);
        check("ho_irq_post", {15'd0, irq}, 16'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
